byte_striping: RTL
==================

BYTE_STRIPING -- requirements
Module: byte_striping

Interface
REQ-001 Parameter PAD_BYTE, default 8'h00, byte written into unfilled lanes on flush.
REQ-002 Parameter NUM_LANES, default 4, fixed at 4; other values unsupported.
REQ-003 clk250k  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in  input  8  serial byte stream, one byte per cycle when in_valid=1.
REQ-006 in_valid  input  1  qualifies in; byte accepted on every edge with in_valid=1.
REQ-007 flush  input  1  closes a partial group, padding remaining lanes.
REQ-008 Lane_0, Lane_1, Lane_2, Lane_3  output  8 each  published lane bytes, held between publishes.
REQ-009 lanes_valid  output  1  one-cycle pulse marking a new publish on Lane_0..Lane_3.
REQ-010 ctr_3  output  2  write slot for the next accepted byte; 0..3.
REQ-011 group_cnt  output  8  count of published groups, wraps 255->0.

Function
REQ-012 Internal shadow registers sh_0..sh_2 (8 bits each) hold bytes of the group being assembled.
REQ-013 Accepted byte with ctr_3=k (k<3): written to sh_k; ctr_3 -> k+1; outputs unchanged.
REQ-014 Accepted byte with ctr_3=3: same edge publishes Lane_0..2 <= sh_0..2, Lane_3 <= in; ctr_3 -> 0; lanes_valid=1 next cycle; group_cnt += 1.
REQ-015 in_valid=0 and flush=0: ctr_3, shadows, lanes all hold; lanes_valid=0.
REQ-016 Byte order: first accepted byte of a group lands on Lane_0, fourth on Lane_3.
REQ-017 flush=1, in_valid=0, ctr_3=k>0: publish sh_0..sh_(k-1) on lanes 0..k-1, PAD_BYTE on lanes k..3; ctr_3 -> 0; lanes_valid pulse; group_cnt += 1.
REQ-018 flush=1, in_valid=1, ctr_3=k: current byte placed on lane k, lanes k+1..3 padded, publish; ctr_3 -> 0 (k=3 identical to REQ-014).
REQ-019 flush=1, in_valid=0, ctr_3=0: no-op; no publish, no pulse, group_cnt unchanged.
REQ-020 lanes_valid is registered, high exactly one cycle per publish; back-to-back groups with continuous in_valid give a pulse every 4th cycle.
REQ-021 Latency: fourth byte accepted at edge N -> Lane_0..3 and lanes_valid=1 visible after edge N; lanes hold until next publish.
REQ-022 ctr_3 wraps 3->0 only through a publish; never skips a value.
REQ-023 Lane outputs are registered; no combinational path from in/in_valid/flush to any output.

Reset
REQ-024 reset=1 immediately, independent of clk250k: Lane_0..3=8'h00, sh_0..2=8'h00, ctr_3=0, lanes_valid=0, group_cnt=0.
REQ-025 reset asserted mid-group discards the partial group; no publish on release.
REQ-026 First edge after reset deassertion with in_valid=1 accepts into slot 0.

Verification
REQ-027 Reset, then in=8'hA1,A2,A3,A4 with in_valid=1 on 4 consecutive edges -> Lane_0..3=A1,A2,A3,A4, lanes_valid=1 one cycle, ctr_3=0, group_cnt=1.
REQ-028 8 consecutive bytes 8'h10..8'h17 -> publishes {10,11,12,13} then {14,15,16,17}, lanes_valid high exactly at cycles 4 and 8, lanes held 4 cycles between.
REQ-029 Bytes 8'h55,8'h66 then flush=1, in_valid=0 (PAD_BYTE=8'h00) -> lanes {55,66,00,00}, one pulse, ctr_3=0; flush again with ctr_3=0 -> no pulse.
REQ-030 Bytes 8'hC0,8'hC1 then in=8'hC2 with in_valid=1 and flush=1 -> lanes {C0,C1,C2,00}, one pulse.
REQ-031 in_valid gaps: 8'hE0, idle 3 cycles, E1, idle, E2, E3 -> single publish {E0,E1,E2,E3}; ctr_3 holds during idles.
REQ-032 Reset asserted between clock edges after 2 bytes -> all outputs 0 at once; next 4 bytes form a fresh group on Lane_0..3; 256 groups -> group_cnt wraps to 0.

Source files
------------

// File: rtl/byte_striping.sv
// Byte striper: gathers a serial byte stream into groups of four and
// publishes each group across four parallel lane registers.
//
// Ports:
//   clk250k      in   1  clock, rising edge
//   reset        in   1  asynchronous active-high reset
//   in           in   8  serial byte
//   in_valid     in   1  qualifies in
//   flush        in   1  closes a partial group, padding the unfilled lanes
//   Lane_0..3    out  8  published lane bytes, held between publishes
//   lanes_valid  out  1  one-cycle pulse per publish
//   ctr_3        out  2  slot the next accepted byte is written to
//   group_cnt    out  8  count of published groups, wraps at 256
module byte_striping #(
    parameter logic [7:0] PAD_BYTE  = 8'h00,
    parameter int         NUM_LANES = 4
) (
    input  logic       clk250k,
    input  logic       reset,
    input  logic [7:0] in,
    input  logic       in_valid,
    input  logic       flush,
    output logic [7:0] Lane_0,
    output logic [7:0] Lane_1,
    output logic [7:0] Lane_2,
    output logic [7:0] Lane_3,
    output logic       lanes_valid,
    output logic [1:0] ctr_3,
    output logic [7:0] group_cnt
);

    logic [7:0] r_sh_0;
    logic [7:0] r_sh_1;
    logic [7:0] r_sh_2;
    logic [7:0] r_lane_0;
    logic [7:0] r_lane_1;
    logic [7:0] r_lane_2;
    logic [7:0] r_lane_3;
    logic       r_lanes_valid;
    logic [1:0] r_ctr;
    logic [7:0] r_group_cnt;

    logic       w_publish;
    logic [7:0] w_lane_0;
    logic [7:0] w_lane_1;
    logic [7:0] w_lane_2;
    logic [7:0] w_lane_3;

    // A group closes when its fourth byte arrives, or on flush when
    // there is something to send (a byte now or bytes already shadowed).
    assign w_publish = (in_valid && (r_ctr == 2'd3)) ||
                       (flush && (in_valid || (r_ctr != 2'd0)));

    // Lanes below the write slot come from the shadows, the slot itself
    // takes the current byte if one is offered, everything above is pad.
    always_comb begin
        w_lane_0 = PAD_BYTE;
        w_lane_1 = PAD_BYTE;
        w_lane_2 = PAD_BYTE;
        w_lane_3 = PAD_BYTE;

        if (r_ctr > 2'd0)
            w_lane_0 = r_sh_0;
        else if (in_valid)
            w_lane_0 = in;

        if (r_ctr > 2'd1)
            w_lane_1 = r_sh_1;
        else if (r_ctr == 2'd1 && in_valid)
            w_lane_1 = in;

        if (r_ctr > 2'd2)
            w_lane_2 = r_sh_2;
        else if (r_ctr == 2'd2 && in_valid)
            w_lane_2 = in;

        if (r_ctr == 2'd3 && in_valid)
            w_lane_3 = in;
    end

    always_ff @(posedge clk250k or posedge reset) begin
        if (reset) begin
            r_sh_0        <= 8'h00;
            r_sh_1        <= 8'h00;
            r_sh_2        <= 8'h00;
            r_lane_0      <= 8'h00;
            r_lane_1      <= 8'h00;
            r_lane_2      <= 8'h00;
            r_lane_3      <= 8'h00;
            r_lanes_valid <= 1'b0;
            r_ctr         <= 2'd0;
            r_group_cnt   <= 8'h00;
        end else begin
            r_lanes_valid <= 1'b0;
            if (w_publish) begin
                r_lane_0      <= w_lane_0;
                r_lane_1      <= w_lane_1;
                r_lane_2      <= w_lane_2;
                r_lane_3      <= w_lane_3;
                r_lanes_valid <= 1'b1;
                r_ctr         <= 2'd0;
                r_group_cnt   <= r_group_cnt + 8'd1;
            end else if (in_valid) begin
                unique case (r_ctr)
                    2'd0:    r_sh_0 <= in;
                    2'd1:    r_sh_1 <= in;
                    default: r_sh_2 <= in;
                endcase
                r_ctr <= r_ctr + 2'd1;
            end
        end
    end

    assign Lane_0      = r_lane_0;
    assign Lane_1      = r_lane_1;
    assign Lane_2      = r_lane_2;
    assign Lane_3      = r_lane_3;
    assign lanes_valid = r_lanes_valid;
    assign ctr_3       = r_ctr;
    assign group_cnt   = r_group_cnt;

endmodule
